truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencing controller for a 3-input single-output logic gate (default function 0xED). It drives every input combination onto the gate in order and waits a programmable settle time at each combination. It then samples the gate output and assembles the measured truth-table byte. It compares that byte against the expected function and reports the result. It sits between a test/configuration host and the `{in1, in2, in3}` / `out` pins of the gate instance.

## Interface
Parameters:
- SETTLE_CYCLES, 4: cycles the input vector is held before sampling. Legal range 1..255.
- EXPECTED, 8'hED: expected truth-table byte. Bit `7-v` is the expected output for input vector `v = {in1,in2,in3}`. Example: 000 maps to bit 7, 111 maps to bit 0.

Ports:
- clk  input  1  single clock. One clock; reset is asynchronous and active-low.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request, sampled in IDLE only.
- abort  input  1  terminate the sweep in progress.
- dut_out  input  1  output of the gate under control.
- in1, in2, in3  output  1 each  registered inputs to the gate; `{in1,in2,in3}` is the current vector.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse when a sweep completes.
- measured  output  8  captured truth table, same bit ordering as EXPECTED.
- mismatch  output  8  `measured ^ EXPECTED`, registered in DONE.
- pass  output  1  high when mismatch == 0. Updated in DONE.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. There is a 3-bit vector counter `vec` and an 8-bit settle counter `cnt`.
- IDLE, with start=1 and abort=0:
  - vec<=0, cnt<=0.
  - measured, mismatch, and pass are cleared.
  - Next state is SETTLE.
- IDLE, otherwise: remain in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - measured[7-vec] <= dut_out.
  - If vec==7, go to DONE.
  - Otherwise vec<=vec+1, cnt<=0, and go to SETTLE.
  - vec does not wrap.
- DONE (one cycle):
  - done=1.
  - mismatch <= measured ^ EXPECTED and pass <= (that value == 0).
  - vec<=0.
  - Next state is IDLE.
- `{in1,in2,in3}` always equals vec, so it is 000 in IDLE and DONE.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE and vec<=0.
  - No SAMPLE capture happens on that edge and done is not pulsed.
  - measured keeps only the bits captured so far; pass stays 0.
- abort in IDLE or DONE has no effect. DONE completes normally.
- start while busy, or in DONE, is ignored. start and abort both high in IDLE: abort wins and the sweep does not start.
- measured, mismatch, and pass hold their values in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, vec=0, cnt=0, in1/in2/in3=0, busy=0, done=0, measured=0, mismatch=0, pass=0.
- Reset mid-sweep returns immediately to these values. Release is synchronous to the next rising edge.
- If start is accepted at edge k:
  - Vector v is driven from edge k+v·(SETTLE_CYCLES+1).
  - Vector v is sampled at edge k+(v+1)·(SETTLE_CYCLES+1).
- done is high in the cycle following edge k+8·(SETTLE_CYCLES+1). With the default of 4 this is edge k+40.
- busy falls at the same edge done rises. A new start is accepted no earlier than the edge after done.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then start with SETTLE_CYCLES=4 and a behavioural 0xED gate model → vectors step 000..111, each held for 5 cycles. done pulses after edge k+40, measured=8'hED, mismatch=8'h00, pass=1.
- Gate model stuck at 1 → measured=8'hFF, mismatch=8'h12, pass=0. Stuck at 0 → measured=8'h00, mismatch=8'hED, pass=0.
- Gate model with 3-cycle output delay, SETTLE_CYCLES=2 → pass=0. Same model with SETTLE_CYCLES=4 → pass=1, measured=8'hED.
- abort asserted during vector 011 SETTLE → IDLE and in=000 on the next edge. No done; measured=8'hE0 (bits 7..5 captured); pass=0.
- start pulsed mid-sweep, and start+abort together in IDLE → the sweep is unaffected, and the simultaneous case never starts (busy stays 0).
- rst_n low during vector 101 → all outputs are immediately at reset values. A subsequent start performs a full, correct sweep.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps {in1,in2,in3} through 000..111, waits a settle time,
// samples the gate output and compares the assembled byte with the expected function.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'hED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] measured,
    output logic [7:0] mismatch,
    output logic       pass
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] vec;
    logic [7:0] cnt;
    logic [7:0] diff;

    assign {in1, in2, in3} = vec;
    assign diff            = measured ^ EXPECTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = SETTLE;
            SETTLE: begin
                if (abort)                state_nxt = IDLE;
                else if (cnt == CNT_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                state_nxt = IDLE;
                else if (vec == 3'd7)     state_nxt = DONE;
                else                      state_nxt = SETTLE;
            end
            DONE:                         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they stay registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            measured <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
        end else begin
            busy <= (state_nxt == SETTLE) || (state_nxt == SAMPLE);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        vec      <= '0;
                        cnt      <= '0;
                        measured <= '0;
                        mismatch <= '0;
                        pass     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) vec <= '0;
                    else       cnt <= cnt + 8'd1;
                end
                SAMPLE: begin
                    if (abort) begin
                        vec <= '0;
                    end else begin
                        measured[3'd7 - vec] <= dut_out;
                        // Vector returns to 000 on entry to DONE so the gate sees 000 there
                        if (vec == 3'd7) begin
                            vec <= '0;
                        end else begin
                            vec <= vec + 3'd1;
                            cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    mismatch <= diff;
                    pass     <= (diff == 8'h00);
                    vec      <= '0;
                end
                default: vec <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: behavioural gate models, directed sweeps,
// abort/reset/start-collision cases, scoreboard of expected results per sweep.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, abort1, dout1;
    logic       in1_1, in2_1, in3_1, busy1, done1, pass1;
    logic [7:0] meas1, mism1;
    logic       start2, abort2, dout2;
    logic       in1_2, in2_2, in3_2, busy2, done2, pass2;
    logic [7:0] meas2, mism2;

    logic [1:0] mode;
    logic [2:0] dl1, dl2;
    logic       sel;
    logic [2:0] obs_vec;
    logic       obs_busy, obs_done, obs_pass;
    logic [7:0] obs_meas, obs_mism;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] meas;
        logic [7:0] mism;
        logic       pass;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hED)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_out(dout1),
        .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
        .measured(meas1), .mismatch(mism1), .pass(pass1)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'hED)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dut_out(dout2),
        .in1(in1_2), .in2(in2_2), .in3(in3_2), .busy(busy2), .done(done2),
        .measured(meas2), .mismatch(mism2), .pass(pass2)
    );

    function automatic logic gate_fn(input logic [2:0] v);
        logic [7:0] tt;
        tt = 8'hED;
        return tt[3'd7 - v];
    endfunction

    // 3-cycle delayed gate models
    always @(posedge clk) begin
        dl1 <= {dl1[1:0], gate_fn({in1_1, in2_1, in3_1})};
        dl2 <= {dl2[1:0], gate_fn({in1_2, in2_2, in3_2})};
    end

    always_comb begin
        dout1 = gate_fn({in1_1, in2_1, in3_1});
        case (mode)
            2'd1:    dout1 = 1'b1;
            2'd2:    dout1 = 1'b0;
            2'd3:    dout1 = dl1[2];
            default: dout1 = gate_fn({in1_1, in2_1, in3_1});
        endcase
        dout2 = dl2[2];
    end

    always_comb begin
        obs_vec  = sel ? {in1_2, in2_2, in3_2} : {in1_1, in2_1, in3_1};
        obs_busy = sel ? busy2 : busy1;
        obs_done = sel ? done2 : done1;
        obs_pass = sel ? pass2 : pass1;
        obs_meas = sel ? meas2 : meas1;
        obs_mism = sel ? mism2 : mism1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    // One full sweep with period s+1; checks vector/busy/done every cycle, then scoreboard.
    task automatic run_sweep(input logic [7:0] exp_meas, input int s, input bit midstart);
        int   period;
        int   total;
        exp_t e;
        period = s + 1;
        total  = 8 * period;
        e.meas = exp_meas;
        e.mism = exp_meas ^ 8'hED;
        e.pass = (e.mism == 8'h00);
        @(negedge clk);
        set_start(1'b1);
        sb.push_back(e);
        @(negedge clk);
        set_start(1'b0);
        for (int j = 0; j <= total; j++) begin
            if (j < total)
                check("sweep_vec_busy_done", {3'b0, obs_vec, obs_busy, obs_done},
                      {3'b0, 3'(j / period), 1'b1, 1'b0});
            else
                check("done_cycle", {3'b0, obs_vec, obs_busy, obs_done}, {3'b0, 3'b000, 1'b0, 1'b1});
            set_start(midstart && (j == 10));
            @(negedge clk);
        end
        set_start(1'b0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check("measured", obs_meas, e.meas);
            check("mismatch", obs_mism, e.mism);
            check("pass_idle", {5'b0, obs_pass, obs_busy, obs_done}, {5'b0, e.pass, 1'b0, 1'b0});
        end
    endtask

    initial begin
        logic saw;
        rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        mode = 2'd0; sel = 1'b0; dl1 = '0; dl2 = '0;
        #1;
        check("reset_ctrl", {3'b0, obs_vec, obs_busy, obs_done}, 8'h00);
        check("reset_meas", meas1, 8'h00);
        check("reset_mism_pass", {mism1[6:0], pass1}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 2'd0; run_sweep(8'hED, 4, 1'b0);
        mode = 2'd1; run_sweep(8'hFF, 4, 1'b0);
        mode = 2'd2; run_sweep(8'h00, 4, 1'b0);
        mode = 2'd3; repeat (4) @(negedge clk); run_sweep(8'hED, 4, 1'b0);
        sel = 1'b1;  run_sweep(8'hF6, 2, 1'b0);
        sel = 1'b0;
        mode = 2'd0; run_sweep(8'hED, 4, 1'b1);

        // start and abort together in IDLE: nothing starts
        @(negedge clk);
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw |= busy1 | done1 | (obs_vec != 3'b000);
            @(negedge clk);
        end
        check("start_abort_idle", {7'b0, saw}, 8'h00);
        check("start_abort_keep_pass", {7'b0, pass1}, 8'h01);

        // abort during vector 011 settle
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_abort_vec", {5'b0, obs_vec}, 8'h03);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_idle", {3'b0, obs_vec, busy1, done1}, 8'h00);
        saw = 1'b0;
        for (int i = 0; i < 45; i++) begin
            saw |= done1 | busy1;
            @(negedge clk);
        end
        check("abort_no_done", {7'b0, saw}, 8'h00);
        check("abort_measured", meas1, 8'hE0);
        check("abort_pass", {mism1[6:0], pass1}, 8'h00);

        // reset during vector 101
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (27) @(negedge clk);
        check("pre_reset_vec", {5'b0, obs_vec}, 8'h05);
        check("pre_reset_meas", meas1, 8'hE8);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {2'b0, obs_vec, busy1, done1, pass1}, 8'h00);
        check("async_reset_meas", meas1, 8'h00);
        check("async_reset_mism", mism1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(8'hED, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
